// File: rtl/cpu_core4.sv
// Execute side of the 4-bit CPU: fetches a ROM byte, runs it on a 4x4 register
// file and pulses inst_done once per retired instruction.
//
// state | meaning
// FETCH | sample rom_inst into IR, or react to rom_done
// EXEC  | decode IR, update registers / leds / flags
// ACK   | inst_done high, ROM advances its PC on this edge
// HALT  | program finished, frozen until reset
module cpu_core4 #(
  parameter bit         HALT_ON_DONE = 1'b1,
  parameter logic [3:0] LED_RST      = 4'h0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  rom_inst,
  input  logic        rom_done,
  output logic        inst_done,
  output logic [3:0]  leds,
  output logic        flag_c,
  output logic        flag_z,
  output logic        halted,
  output logic [15:0] dbg_regs
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [7:0]      ir_q, ir_d;
  logic [3:0][3:0] rf_q, rf_d;
  logic [3:0]      leds_q, leds_d;
  logic            c_q, c_d;
  logic            z_q, z_d;

  logic [3:0] src_val;
  logic [3:0] dst_val;
  logic [3:0] alu_res;
  logic       alu_c;
  logic [4:0] alu_sum;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_FETCH;
      ir_q    <= 8'h00;
      rf_q    <= '0;
      leds_q  <= LED_RST;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      rf_q    <= rf_d;
      leds_q  <= leds_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  // Operands come from the pre-write register file, so Rs==Rd sees the old value.
  always_comb begin
    src_val = rf_q[ir_q[3:2]];
    dst_val = rf_q[ir_q[1:0]];
    alu_sum = {1'b0, dst_val} + {1'b0, src_val};
    alu_res = 4'h0;
    alu_c   = 1'b0;
    case (ir_q[5:4])
      2'b00: begin
        alu_res = alu_sum[3:0];
        alu_c   = alu_sum[4];
      end
      2'b01: begin
        alu_res = dst_val - src_val;
        alu_c   = (dst_val < src_val);
      end
      2'b10:   alu_res = dst_val & src_val;
      default: alu_res = ~src_val;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    rf_d    = rf_q;
    leds_d  = leds_q;
    c_d     = c_q;
    z_d     = z_q;
    case (state_q)
      S_FETCH: begin
        if (rom_done) begin
          if (HALT_ON_DONE) state_d = S_HALT;
        end else begin
          ir_d    = rom_inst;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_ACK;
        case (ir_q[7:6])
          2'b00: rf_d[ir_q[5:4]] = ir_q[3:0];
          2'b01: leds_d = src_val;
          2'b10: rf_d[ir_q[5:4]] = src_val;
          default: begin
            rf_d[ir_q[1:0]] = alu_res;
            c_d             = alu_c;
            z_d             = (alu_res == 4'h0);
          end
        endcase
      end
      S_ACK:   state_d = S_FETCH;
      default: state_d = S_HALT;
    endcase
  end

  assign inst_done = (state_q == S_ACK);
  assign halted    = (state_q == S_HALT);
  assign leds      = leds_q;
  assign flag_c    = c_q;
  assign flag_z    = z_q;
  assign dbg_regs  = rf_q;

endmodule

// File: tb/tb_cpu_core4.sv
// Directed bench for cpu_core4: table-driven programs through a small ROM model,
// plus hand-written reset, early-halt and no-halt sequences.
module tb_cpu_core4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, clr2;
  logic [7:0]  rom_inst, rom_inst2;
  logic        rom_done, rom_done2;
  logic        inst_done, inst_done2;
  logic [3:0]  leds, leds2;
  logic        flag_c, flag_c2, flag_z, flag_z2;
  logic        halted, halted2;
  logic [15:0] dbg_regs, dbg_regs2;

  cpu_core4 u_dut (
    .clk(clk), .clr(clr), .rom_inst(rom_inst), .rom_done(rom_done),
    .inst_done(inst_done), .leds(leds), .flag_c(flag_c), .flag_z(flag_z),
    .halted(halted), .dbg_regs(dbg_regs)
  );

  cpu_core4 #(.HALT_ON_DONE(1'b0), .LED_RST(4'hA)) u_dut2 (
    .clk(clk), .clr(clr2), .rom_inst(rom_inst2), .rom_done(rom_done2),
    .inst_done(inst_done2), .leds(leds2), .flag_c(flag_c2), .flag_z(flag_z2),
    .halted(halted2), .dbg_regs(dbg_regs2)
  );

  // ROM model: PC advances on the edge that ends ACK.
  logic [7:0] rom [0:15];
  int         plen = 0;
  int         pc;
  always @(posedge clk or negedge clr) begin
    if (!clr) pc <= 0;
    else if (inst_done) pc <= pc + 1;
  end
  assign rom_inst = (pc < plen) ? rom[pc[3:0]] : 8'h00;
  assign rom_done = (pc >= plen);

  typedef struct {
    logic [7:0]  inst;
    logic [15:0] regs;
    logic [3:0]  leds;
    logic        c;
    logic        z;
  } vec_t;
  vec_t vecs [0:20];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_pulse(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!inst_done && k < 12);
  endtask

  task automatic run_prog(input int first, input int n);
    int k;
    clr = 1'b0;
    for (int i = 0; i < n; i++) rom[i] = vecs[first + i].inst;
    plen = n;
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < n; i++) begin
      wait_pulse(k);
      check($sformatf("latency[%0d]", first + i), k, (i == 0) ? 2 : 3);
      if (!inst_done) return;
      check($sformatf("regs[%0d]", first + i), dbg_regs, vecs[first + i].regs);
      check($sformatf("leds[%0d]", first + i), leds, vecs[first + i].leds);
      check($sformatf("flag_c[%0d]", first + i), flag_c, vecs[first + i].c);
      check($sformatf("flag_z[%0d]", first + i), flag_z, vecs[first + i].z);
    end
    @(negedge clk);
    @(negedge clk);
    check("halted_after_prog", halted, 1'b1);
    k = 0;
    repeat (4) begin
      @(negedge clk);
      if (inst_done) k++;
    end
    check("pulses_in_halt", k, 0);
    check("regs_in_halt", dbg_regs, vecs[first + n - 1].regs);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    // Program A: the reference program ending in a borrow.
    vecs[0]  = '{8'h05, 16'h0005, 4'h0, 1'b0, 1'b0};
    vecs[1]  = '{8'h14, 16'h0045, 4'h0, 1'b0, 1'b0};
    vecs[2]  = '{8'h23, 16'h0345, 4'h0, 1'b0, 1'b0};
    vecs[3]  = '{8'h32, 16'h2345, 4'h0, 1'b0, 1'b0};
    vecs[4]  = '{8'hD9, 16'h2315, 4'h0, 1'b0, 1'b0};
    vecs[5]  = '{8'hC4, 16'h2316, 4'h0, 1'b0, 1'b0};
    vecs[6]  = '{8'hEE, 16'h2216, 4'h0, 1'b0, 1'b0};
    vecs[7]  = '{8'hD3, 16'hC216, 4'h0, 1'b1, 1'b0};
    vecs[8]  = '{8'h40, 16'hC216, 4'h6, 1'b1, 1'b0};
    vecs[9]  = '{8'h84, 16'hC211, 4'h6, 1'b1, 1'b0};
    // Program B: carry/zero, flag persistence, self ops, NOT/SUB to zero.
    vecs[10] = '{8'h0F, 16'h000F, 4'h0, 1'b0, 1'b0};
    vecs[11] = '{8'h11, 16'h001F, 4'h0, 1'b0, 1'b0};
    vecs[12] = '{8'hC1, 16'h000F, 4'h0, 1'b1, 1'b1};
    vecs[13] = '{8'h05, 16'h0005, 4'h0, 1'b1, 1'b1};
    vecs[14] = '{8'h29, 16'h0905, 4'h0, 1'b1, 1'b1};
    vecs[15] = '{8'hCA, 16'h0205, 4'h0, 1'b1, 1'b0};
    vecs[16] = '{8'hFA, 16'h0D05, 4'h0, 1'b0, 1'b0};
    vecs[17] = '{8'h3F, 16'hFD05, 4'h0, 1'b0, 1'b0};
    vecs[18] = '{8'hFF, 16'h0D05, 4'h0, 1'b0, 1'b1};
    vecs[19] = '{8'hDA, 16'h0005, 4'h0, 1'b0, 1'b1};
    vecs[20] = '{8'h8C, 16'h0000, 4'h0, 1'b0, 1'b1};

    clr = 1'b0; clr2 = 1'b0;
    rom_inst2 = 8'h00; rom_done2 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_regs", dbg_regs, 16'h0000);
    check("rst_leds", leds, 4'h0);
    check("rst_inst_done", inst_done, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_leds_param", leds2, 4'hA);

    run_prog(0, 10);
    run_prog(10, 11);

    // Reset asserted during EXEC of the 4th instruction.
    clr = 1'b0;
    rom[0] = 8'h3F; rom[1] = 8'h7C; rom[2] = 8'hCF; rom[3] = 8'h2C;
    plen = 4;
    @(negedge clk);
    clr = 1'b1;
    repeat (3) wait_pulse(k);
    check("pre_reset_regs", dbg_regs, 16'hE000);
    check("pre_reset_leds", leds, 4'hF);
    check("pre_reset_c", flag_c, 1'b1);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("midexec_regs", dbg_regs, 16'h0000);
    check("midexec_leds", leds, 4'h0);
    check("midexec_c", flag_c, 1'b0);
    check("midexec_z", flag_z, 1'b0);
    check("midexec_inst_done", inst_done, 1'b0);
    check("midexec_halted", halted, 1'b0);
    k = 0;
    repeat (3) begin
      @(negedge clk);
      if (inst_done) k++;
    end
    check("pulses_in_reset", k, 0);

    // rom_done already high in the very first FETCH.
    rom[0] = 8'h3F;
    plen = 0;
    @(negedge clk);
    clr = 1'b1;
    k = 0;
    repeat (5) begin
      @(negedge clk);
      if (inst_done) k++;
    end
    check("early_halt_pulses", k, 0);
    check("early_halt_halted", halted, 1'b1);
    check("early_halt_regs", dbg_regs, 16'h0000);

    // No-halt variant: a one-cycle rom_done pulse just delays the fetch.
    rom_inst2 = 8'h3F; rom_done2 = 1'b1;
    @(negedge clk);
    clr2 = 1'b1;
    @(negedge clk);
    check("nohalt_halted", halted2, 1'b0);
    check("nohalt_no_latch", dbg_regs2, 16'h0000);
    rom_done2 = 1'b0; rom_inst2 = 8'h27;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!inst_done2 && k < 12);
    check("nohalt_latency", k, 2);
    check("nohalt_regs", dbg_regs2, 16'h0700);
    rom_done2 = 1'b1;
    repeat (4) @(negedge clk);
    check("nohalt_still_running", halted2, 1'b0);
    check("nohalt_leds", leds2, 4'hA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
